// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: sequencer states and
// the bundle of per-stage freeze/flush controls.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   typedef struct packed {
      logic freeze_pc;
      logic freeze_if_id;
      logic flush_if_id;
      logic freeze_id_exe;
      logic flush_id_exe;
      logic freeze_exe_mem;
      logic freeze_mem_wb;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_NONE = '0;

   localparam stage_ctrl_t CTRL_ALL_FREEZE = '{
      freeze_pc: 1'b1, freeze_if_id: 1'b1, flush_if_id: 1'b0,
      freeze_id_exe: 1'b1, flush_id_exe: 1'b0,
      freeze_exe_mem: 1'b1, freeze_mem_wb: 1'b1};

   localparam stage_ctrl_t CTRL_BRANCH_FLUSH = '{
      freeze_pc: 1'b0, freeze_if_id: 1'b0, flush_if_id: 1'b1,
      freeze_id_exe: 1'b0, flush_id_exe: 1'b1,
      freeze_exe_mem: 1'b0, freeze_mem_wb: 1'b0};

   // Older instructions drain while the dependent one is held in ID.
   localparam stage_ctrl_t CTRL_HAZARD_BUBBLE = '{
      freeze_pc: 1'b1, freeze_if_id: 1'b1, flush_if_id: 1'b0,
      freeze_id_exe: 1'b0, flush_id_exe: 1'b1,
      freeze_exe_mem: 1'b0, freeze_mem_wb: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Wrapping event counter with enable and synchronous active-low reset.
module perf_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)  count <= '0;
      else if (en) count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory stalls,
// branch flushes and RAW bubbles, with a memory-wait watchdog and perf counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             err_clr,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             flush_if_id,
   output logic             freeze_id_exe,
   output logic             flush_id_exe,
   output logic             freeze_exe_mem,
   output logic             freeze_mem_wb,
   output logic             busy,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   state_t         state, state_nxt;
   logic [WW-1:0]  wait_cnt, wait_nxt;
   stage_ctrl_t    ctrl, ctrl_out;
   logic           flush_evt;
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // wait_cnt counts frozen cycles of the current access, entry cycle included.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      ctrl      = CTRL_NONE;
      flush_evt = 1'b0;
      case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               ctrl      = CTRL_ALL_FREEZE;
               state_nxt = MEM_WAIT;
               wait_nxt  = WW'(1);
            end else if (branch_taken) begin
               ctrl      = CTRL_BRANCH_FLUSH;
               flush_evt = 1'b1;
            end else if (hazard_detected) begin
               ctrl = CTRL_HAZARD_BUBBLE;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else begin
               ctrl = CTRL_ALL_FREEZE;
               if (wait_cnt == WW'(MEM_TIMEOUT)) state_nxt = ERROR;
               else                              wait_nxt  = wait_cnt + WW'(1);
            end
         end
         ERROR: begin
            ctrl = CTRL_ALL_FREEZE;
            if (err_clr) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // Outputs are forced quiet for the whole time reset is held, not just after the edge.
   assign ctrl_out       = rst_n ? ctrl : CTRL_NONE;
   assign freeze_pc      = ctrl_out.freeze_pc;
   assign freeze_if_id   = ctrl_out.freeze_if_id;
   assign flush_if_id    = ctrl_out.flush_if_id;
   assign freeze_id_exe  = ctrl_out.freeze_id_exe;
   assign flush_id_exe   = ctrl_out.flush_id_exe;
   assign freeze_exe_mem = ctrl_out.freeze_exe_mem;
   assign freeze_mem_wb  = ctrl_out.freeze_mem_wb;
   assign busy           = rst_n && (state != RUN);
   assign mem_timeout    = rst_n && (state == ERROR);

   perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ctrl_out.freeze_pc),
      .count (stall_q)
   );

   perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (flush_evt),
      .count (flush_q)
   );

   assign stall_cnt = rst_n ? stall_q : '0;
   assign flush_cnt = rst_n ? flush_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model of the sequencer rules.
module tb_pipeline_hazard_ctrl;

   localparam int TO = 4;
   localparam int CW = 8;
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] ALLF = 7'b1101011;
   localparam logic [6:0] HAZ  = 7'b1100100;
   localparam logic [6:0] BRF  = 7'b0010100;

   logic clk = 1'b0;
   logic rst_n, hazard_detected, branch_taken, mem_req, mem_ready, err_clr;
   logic freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe;
   logic freeze_exe_mem, freeze_mem_wb, busy, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int passed = 0;
   int total  = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .err_clr(err_clr), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
      .flush_if_id(flush_if_id), .freeze_id_exe(freeze_id_exe),
      .flush_id_exe(flush_id_exe), .freeze_exe_mem(freeze_exe_mem),
      .freeze_mem_wb(freeze_mem_wb), .busy(busy), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, hz, br, rq, rd, cl;
      logic [6:0] ectrl;
      logic       ebusy, emto;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [6:0] ctrl_now();
      return {freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe,
              flush_id_exe, freeze_exe_mem, freeze_mem_wb};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      else passed++;
   endtask

   // Drive inputs just after a rising edge and settle to the falling edge.
   task automatic apply(input logic r, hz, br, rq, rd, cl);
      rst_n = r; hazard_detected = hz; branch_taken = br;
      mem_req = rq; mem_ready = rd; err_clr = cl;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(0, 0, 0, 0, 0, 0); adv();
      apply(0, 0, 0, 0, 0, 0); adv();
   endtask

   // Behavioural model: mode 0 running, 1 waiting on memory, 2 timed out.
   int          m_mode, m_frozen;
   int unsigned m_stall, m_flush;

   task automatic model_step(input logic hz, br, rq, rd, cl,
                             output logic [6:0] ec, output logic eb, output logic em);
      ec = NONE; eb = (m_mode != 0); em = (m_mode == 2);
      if (m_mode == 2) begin
         ec = ALLF;
         if (cl) begin m_mode = 0; m_frozen = 0; end
      end else if (m_mode == 1) begin
         if (rd) begin
            m_mode = 0; m_frozen = 0;
         end else begin
            ec = ALLF;
            m_frozen++;
            if (m_frozen > TO) m_mode = 2;
         end
      end else begin
         if (rq && !rd) begin
            ec = ALLF; m_mode = 1; m_frozen = 1;
         end else if (br) begin
            ec = BRF; m_flush = (m_flush + 1) % (1 << CW);
         end else if (hz) begin
            ec = HAZ;
         end
      end
      if (ec[6]) m_stall = (m_stall + 1) % (1 << CW);
   endtask

   initial begin
      int fr, bz, fl;
      logic [6:0] ec;
      logic eb, em;
      logic hz, br, rq, rd, cl;

      tbl[0]  = '{0, 1, 1, 1, 0, 0, NONE, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, NONE, 0, 0};
      tbl[2]  = '{1, 1, 0, 0, 0, 0, HAZ,  0, 0};
      tbl[3]  = '{1, 1, 0, 0, 0, 0, HAZ,  0, 0};
      tbl[4]  = '{1, 1, 1, 0, 0, 0, BRF,  0, 0};
      tbl[5]  = '{1, 1, 1, 1, 0, 0, ALLF, 0, 0};
      tbl[6]  = '{1, 1, 1, 1, 0, 0, ALLF, 1, 0};
      tbl[7]  = '{1, 0, 1, 1, 1, 0, NONE, 1, 0};
      tbl[8]  = '{1, 1, 1, 0, 0, 0, BRF,  0, 0};
      tbl[9]  = '{1, 0, 0, 1, 1, 0, NONE, 0, 0};
      tbl[10] = '{1, 0, 0, 0, 0, 1, NONE, 0, 0};

      apply(0, 0, 0, 0, 0, 0); adv();
      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].hz, tbl[i].br, tbl[i].rq, tbl[i].rd, tbl[i].cl);
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ectrl));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
         chk($sformatf("vec%0d_mto", i), 32'(mem_timeout), 32'(tbl[i].emto));
         adv();
      end

      // Hazard only
      do_reset();
      chk("reset_stall_cnt", 32'(stall_cnt), 0);
      chk("reset_flush_cnt", 32'(flush_cnt), 0);
      for (int k = 0; k < 2; k++) begin
         apply(1, 1, 0, 0, 0, 0);
         chk("haz_ctrl", 32'(ctrl_now()), 32'(HAZ));
         adv();
      end
      apply(1, 0, 0, 0, 0, 0);
      chk("haz_release", 32'(ctrl_now()), 32'(NONE));
      chk("haz_stall_cnt", 32'(stall_cnt), 2);

      // Branch and hazard together
      adv(); do_reset();
      apply(1, 1, 1, 0, 0, 0);
      chk("brhaz_ctrl", 32'(ctrl_now()), 32'(BRF));
      adv();
      chk("brhaz_flush_cnt", 32'(flush_cnt), 1);
      chk("brhaz_stall_cnt", 32'(stall_cnt), 0);

      // Memory wait of 3 not-ready cycles then ready
      do_reset();
      fr = 0; bz = 0;
      for (int k = 0; k < 3; k++) begin
         apply(1, 0, 0, 1, 0, 0);
         if (ctrl_now() == ALLF) fr++;
         if (busy && freeze_pc) bz++;
         adv();
      end
      apply(1, 0, 0, 1, 1, 0);
      chk("memw_ready_ctrl", 32'(ctrl_now()), 32'(NONE));
      adv();
      chk("memw_frozen", fr, 3);
      chk("memw_busy_frozen", bz, 2);
      chk("memw_stall_cnt", 32'(stall_cnt), 3);
      apply(1, 0, 0, 0, 0, 0);
      chk("memw_busy_after", 32'(busy), 0);
      adv();

      // Branch during a 2-cycle wait
      do_reset();
      fl = 0;
      apply(1, 0, 1, 1, 0, 0); if (flush_if_id || flush_id_exe) fl++; adv();
      apply(1, 0, 1, 1, 0, 0); if (flush_if_id || flush_id_exe) fl++; adv();
      apply(1, 0, 1, 1, 1, 0); if (flush_if_id || flush_id_exe) fl++; adv();
      chk("brwait_no_flush", fl, 0);
      apply(1, 0, 1, 0, 0, 0);
      chk("brwait_flush_ctrl", 32'(ctrl_now()), 32'(BRF));
      adv();
      chk("brwait_flush_cnt", 32'(flush_cnt), 1);

      // Watchdog trip, ready ignored in ERROR, then err_clr
      do_reset();
      for (int k = 1; k <= TO + 1; k++) begin
         apply(1, 0, 0, 1, 0, 0);
         chk($sformatf("wd_frozen%0d", k), 32'(ctrl_now()), 32'(ALLF));
         chk($sformatf("wd_mto%0d", k), 32'(mem_timeout), 0);
         adv();
      end
      apply(1, 0, 0, 1, 1, 0);
      chk("wd_err_busy", 32'(busy), 1);
      chk("wd_err_mto", 32'(mem_timeout), 1);
      chk("wd_err_ctrl", 32'(ctrl_now()), 32'(ALLF));
      adv();
      apply(1, 0, 0, 0, 0, 1);
      chk("wd_clr_cycle_mto", 32'(mem_timeout), 1);
      adv();
      apply(1, 0, 0, 0, 0, 0);
      chk("wd_clr_mto", 32'(mem_timeout), 0);
      chk("wd_clr_busy", 32'(busy), 0);
      chk("wd_clr_ctrl", 32'(ctrl_now()), 32'(NONE));
      adv();
      for (int k = 1; k <= TO; k++) begin apply(1, 0, 0, 1, 0, 0); adv(); end
      apply(1, 0, 0, 1, 1, 0);
      chk("wd_late_ready_ctrl", 32'(ctrl_now()), 32'(NONE));
      adv();
      apply(1, 0, 0, 0, 0, 0);
      chk("wd_late_ready_mto", 32'(mem_timeout), 0);
      chk("wd_late_ready_busy", 32'(busy), 0);
      adv();

      // Reset mid-wait
      do_reset();
      for (int k = 0; k < 4; k++) begin apply(1, 1, 0, 0, 0, 0); adv(); end
      for (int k = 0; k < 3; k++) begin apply(1, 0, 0, 1, 0, 0); adv(); end
      chk("rstw_stall_pre", 32'(stall_cnt), 7);
      apply(0, 1, 1, 1, 0, 1);
      chk("rstw_ctrl", 32'(ctrl_now()), 32'(NONE));
      chk("rstw_busy", 32'(busy), 0);
      chk("rstw_stall", 32'(stall_cnt), 0);
      adv();
      apply(1, 0, 0, 0, 0, 0);
      chk("rstw_busy_after", 32'(busy), 0);
      chk("rstw_stall_after", 32'(stall_cnt), 0);
      chk("rstw_ctrl_after", 32'(ctrl_now()), 32'(NONE));
      adv();

      // Counter wrap at 2^CNT_W
      do_reset();
      for (int k = 0; k < (1 << CW); k++) begin apply(1, 1, 0, 0, 0, 0); adv(); end
      chk("wrap_stall_zero", 32'(stall_cnt), 0);
      apply(1, 1, 0, 0, 0, 0); adv();
      chk("wrap_stall_one", 32'(stall_cnt), 1);

      // Randomized run against the model
      do_reset();
      m_mode = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
      for (int n = 0; n < 1500; n++) begin
         hz = 1'($urandom_range(0, 1));
         br = ($urandom_range(0, 3) == 0);
         rq = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 3) == 0);
         cl = ($urandom_range(0, 7) == 0);
         model_step(hz, br, rq, rd, cl, ec, eb, em);
         apply(1, hz, br, rq, rd, cl);
         chk("rnd_ctrl", 32'(ctrl_now()), 32'(ec));
         chk("rnd_busy", 32'(busy), 32'(eb));
         chk("rnd_mto", 32'(mem_timeout), 32'(em));
         adv();
         chk("rnd_stall_cnt", 32'(stall_cnt), m_stall);
         chk("rnd_flush_cnt", 32'(flush_cnt), m_flush);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
